prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 23 ++
 rtl/prog_loader_uart_rx.sv | 106 ++++++++++
 rtl/prog_loader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared constants for the serial program loader: frame sync
//               byte and state encodings for the loader and UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LEN  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_SUM  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/prog_loader_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with 2-flop input synchronizer, start-bit
//               glitch rejection and stop-bit framing check.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] data_byte,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] c_half_m1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_full_m1 = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    r_sync;
    logic          r_prev;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_valid;
    logic          r_ferr;
    logic [7:0]    r_byte;
    logic          w_rxd;

    assign w_rxd      = r_sync[1];
    assign byte_valid = r_valid;
    assign data_byte  = r_byte;
    assign frame_err  = r_ferr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync    <= 2'b11;
            r_prev    <= 1'b1;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_byte    <= '0;
        end else begin
            r_sync  <= {r_sync[0], rxd};
            r_prev  <= w_rxd;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (r_prev && !w_rxd) begin
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was only a glitch
                    if (r_cnt == c_half_m1) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rxd ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == c_full_m1) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rxd, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_cnt == c_full_m1) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (w_rxd) begin
                            r_valid <= 1'b1;
                            r_byte  <= r_shift;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Receives a framed program image over UART, writes it into
//               program RAM and holds the CPU in reset until it verifies.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLK_HZ       = 27000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_CLKS = 2700000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] c_timeout = TW'(TIMEOUT_CLKS);

    logic       w_valid;
    logic [7:0] w_byte;
    logic       w_ferr;
    logic       w_timeout;

    logic [1:0]    r_state;
    logic [8:0]    r_count;
    logic [7:0]    r_addr;
    logic [7:0]    r_sum;
    logic [TW-1:0] r_timer;
    logic          r_we;
    logic [7:0]    r_waddr;
    logic [7:0]    r_wdata;
    logic          r_hold;
    logic          r_done;
    logic          r_err;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .byte_valid (w_valid),
        .data_byte  (w_byte),
        .frame_err  (w_ferr)
    );

    assign mem_we    = r_we;
    assign mem_addr  = r_waddr;
    assign mem_wdata = r_wdata;
    assign cpu_hold  = r_hold;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;

    assign w_timeout = (r_state != ST_IDLE) && (r_timer == c_timeout);

    // Inter-byte gap timer: restarts on every received byte, idle outside a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (r_state == ST_IDLE || w_valid) begin
            r_timer <= '0;
        end else if (r_timer != c_timeout) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_addr  <= '0;
            r_sum   <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            if (r_state != ST_IDLE && (w_ferr || w_timeout)) begin
                r_err   <= 1'b1;
                r_state <= ST_IDLE;
            end else if (w_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_byte == SYNC_BYTE) begin
                            r_state <= ST_LEN;
                            r_hold  <= 1'b1;
                            r_err   <= 1'b0;
                        end
                    end
                    ST_LEN: begin
                        r_count <= (w_byte == 8'd0) ? 9'd256 : {1'b0, w_byte};
                        r_addr  <= '0;
                        r_sum   <= '0;
                        r_state <= ST_DATA;
                    end
                    ST_DATA: begin
                        r_we    <= 1'b1;
                        r_waddr <= r_addr;
                        r_wdata <= w_byte;
                        r_addr  <= r_addr + 1'b1;
                        r_sum   <= r_sum + w_byte;
                        r_count <= r_count - 1'b1;
                        if (r_count == 9'd1) begin
                            r_state <= ST_SUM;
                        end
                    end
                    ST_SUM: begin
                        // On mismatch the CPU stays held so it never runs a bad image
                        if (w_byte == r_sum) begin
                            r_done <= 1'b1;
                            r_hold <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
